// File: rtl/cdb_pkg.sv
// Shared types and default widths for the common-data-bus scheduler.
package cdb_pkg;

  localparam int XLEN          = 32;
  localparam int ROB_TAG_WIDTH = 5;

  typedef struct packed {
    logic [XLEN-1:0]          value;
    logic [ROB_TAG_WIDTH-1:0] tag;
  } cdb_packet_t;

endpackage

// File: rtl/lsb_fixed_priority_arbiter.sv
// One-hot grant of the lowest-indexed asserted request bit.
module lsb_fixed_priority_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  // Two's complement isolates the lowest set bit.
  assign gnt_o = req_i & (-req_i);

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin one-hot arbiter: first request at or above ptr_i, wrapping to index 0.
module round_robin_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);

  logic [N-1:0] mask;
  logic [N-1:0] req_masked;
  logic [N-1:0] gnt_masked;
  logic [N-1:0] gnt_unmasked;

  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i >= int'(ptr_i));
    end
  end

  assign req_masked = req_i & mask;

  lsb_fixed_priority_arbiter #(.N(N)) u_masked (
    .req_i (req_masked),
    .gnt_o (gnt_masked)
  );

  lsb_fixed_priority_arbiter #(.N(N)) u_unmasked (
    .req_i (req_i),
    .gnt_o (gnt_unmasked)
  );

  // Nothing at or above the pointer means the search wraps to the low indices.
  assign gnt_o = (|gnt_masked) ? gnt_masked : gnt_unmasked;

endmodule

// File: rtl/cdb_scheduler.sv
// Per-unit holding registers feeding a single CDB, one broadcast per cycle.
// Define CDB_SCHED_FIXED_PRIORITY_EN for LSB fixed priority instead of round-robin.
module cdb_scheduler #(
  parameter int N             = 4,
  parameter int XLEN          = cdb_pkg::XLEN,
  parameter int ROB_TAG_WIDTH = cdb_pkg::ROB_TAG_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic [N-1:0]               fu_valid,
  input  logic [N*XLEN-1:0]          fu_value,
  input  logic [N*ROB_TAG_WIDTH-1:0] fu_tag,
  output logic [N-1:0]               fu_ready,
  output logic                       cdb_valid,
  output logic [XLEN-1:0]            cdb_value,
  output logic [ROB_TAG_WIDTH-1:0]   cdb_tag,
  output logic [N-1:0]               cdb_grant
);

  import cdb_pkg::*;

  logic [N-1:0]             occ_q, occ_d;
  logic [XLEN-1:0]          val_q [N];
  logic [XLEN-1:0]          val_d [N];
  logic [ROB_TAG_WIDTH-1:0] tag_q [N];
  logic [ROB_TAG_WIDTH-1:0] tag_d [N];
  logic [N-1:0]             arb_gnt;
  logic [N-1:0]             gnt;

`ifdef CDB_SCHED_FIXED_PRIORITY_EN
  lsb_fixed_priority_arbiter #(.N(N)) u_arb (
    .req_i (occ_q),
    .gnt_o (arb_gnt)
  );
`else
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;

  round_robin_arbiter #(.N(N), .PTR_W(PW)) u_arb (
    .req_i (occ_q),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt)
  );

  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) ptr_d = (i == N - 1) ? '0 : PW'(i + 1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
`endif

  // Flush silences the bus and refuses new results for the whole cycle.
  assign gnt       = flush ? '0 : arb_gnt;
  assign cdb_grant = gnt;
  assign cdb_valid = |gnt;
  assign fu_ready  = flush ? '0 : (~occ_q | gnt);

  always_comb begin
    cdb_value = '0;
    cdb_tag   = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        cdb_value = cdb_value | val_q[i];
        cdb_tag   = cdb_tag | tag_q[i];
      end
    end
  end

  // A load takes precedence over the drain so a granted register refills in place.
  always_comb begin
    occ_d = occ_q;
    for (int i = 0; i < N; i++) begin
      val_d[i] = val_q[i];
      tag_d[i] = tag_q[i];
      if (flush) begin
        occ_d[i] = 1'b0;
      end else if (fu_valid[i] && fu_ready[i]) begin
        occ_d[i] = 1'b1;
        val_d[i] = fu_value[i*XLEN +: XLEN];
        tag_d[i] = fu_tag[i*ROB_TAG_WIDTH +: ROB_TAG_WIDTH];
      end else if (gnt[i]) begin
        occ_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q <= '0;
      for (int i = 0; i < N; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      occ_q <= occ_d;
      for (int i = 0; i < N; i++) begin
        val_q[i] <= val_d[i];
        tag_q[i] <= tag_d[i];
      end
    end
  end

  grant_onehot_a: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(cdb_grant));

  flush_quiet_a: assert property (@(posedge clk) disable iff (!reset_n)
    flush |-> (cdb_grant == '0 && fu_ready == '0));

endmodule

// File: tb/tb_cdb_scheduler.sv
// Directed bench for cdb_scheduler with hand-computed expected broadcasts.
module tb_cdb_scheduler;

  import cdb_pkg::*;

  localparam int N  = 4;
  localparam int TW = ROB_TAG_WIDTH;

  logic                clk      = 1'b0;
  logic                reset_n  = 1'b0;
  logic                flush    = 1'b0;
  logic [N-1:0]        fu_valid = '0;
  logic [N*XLEN-1:0]   fu_value = '0;
  logic [N*TW-1:0]     fu_tag   = '0;
  logic [N-1:0]        fu_ready;
  logic                cdb_valid;
  logic [XLEN-1:0]     cdb_value;
  logic [TW-1:0]       cdb_tag;
  logic [N-1:0]        cdb_grant;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cdb_scheduler #(.N(N), .XLEN(XLEN), .ROB_TAG_WIDTH(TW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .fu_valid  (fu_valid),
    .fu_value  (fu_value),
    .fu_tag    (fu_tag),
    .fu_ready  (fu_ready),
    .cdb_valid (cdb_valid),
    .cdb_value (cdb_value),
    .cdb_tag   (cdb_tag),
    .cdb_grant (cdb_grant)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bcast_chk(input string tag, input logic [N-1:0] g,
                           input logic [XLEN-1:0] v, input logic [TW-1:0] t);
    cdb_packet_t p;
    p.value = v;
    p.tag   = t;
    chk({tag, "_valid"}, 64'(cdb_valid), 64'd1);
    chk({tag, "_grant"}, 64'(cdb_grant), 64'(g));
    chk({tag, "_value"}, 64'(cdb_value), 64'(p.value));
    chk({tag, "_tag"},   64'(cdb_tag),   64'(p.tag));
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_valid"}, 64'(cdb_valid), 64'd0);
    chk({tag, "_grant"}, 64'(cdb_grant), 64'd0);
  endtask

  task automatic put(input int u, input logic [XLEN-1:0] v, input logic [TW-1:0] t);
    fu_valid[u]          = 1'b1;
    fu_value[u*XLEN +: XLEN] = v;
    fu_tag[u*TW +: TW]   = t;
  endtask

  task automatic clr();
    fu_valid = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] exp_rdy;

    // Reset held with every unit presenting a result
    for (int i = 0; i < N; i++) put(i, XLEN'(32'hEE + i), TW'(i));
    #2;
    idle_chk("rst");
    chk("rst_ready", 64'(fu_ready), 64'hF);
    chk("rst_value", 64'(cdb_value), 64'd0);
    chk("rst_tag",   64'(cdb_tag),   64'd0);
    step(); step();
    idle_chk("rst_hold");
    clr();
    reset_n = 1'b1;
    #1;
    idle_chk("post_rst");
    chk("post_rst_ready", 64'(fu_ready), 64'hF);
    step();
    idle_chk("post_rst_nocap");

`ifdef CDB_SCHED_FIXED_PRIORITY_EN
    put(0, 32'h0, 5'd0);
    put(3, 32'h30, 5'd3);
    step();
    for (int k = 0; k < 3; k++) begin
      put(0, XLEN'(k + 1), 5'd0);
      #1;
      bcast_chk("fp", 4'b0001, XLEN'(k), 5'd0);
      chk("fp_ready3", 64'(fu_ready[3]), 64'd0);
      step();
    end
    clr();
`else
    // First accepted result appears one cycle later
    put(1, 32'h55, 5'd7);
    #1;
    chk("acc_ready1", 64'(fu_ready[1]), 64'd1);
    idle_chk("acc_same_cycle");
    step(); clr(); #1;
    bcast_chk("first", 4'b0010, 32'h55, 5'd7);
    step(); #1;
    idle_chk("first_done");

    // Single unit streaming back to back
    put(2, 32'h10, 5'd3);
    #1;
    chk("ss_ready0", 64'(fu_ready[2]), 64'd1);
    step(); put(2, 32'h11, 5'd3); #1;
    chk("ss_ready1", 64'(fu_ready[2]), 64'd1);
    bcast_chk("ss0", 4'b0100, 32'h10, 5'd3);
    step(); put(2, 32'h12, 5'd3); #1;
    chk("ss_ready2", 64'(fu_ready[2]), 64'd1);
    bcast_chk("ss1", 4'b0100, 32'h11, 5'd3);
    step(); clr(); #1;
    bcast_chk("ss2", 4'b0100, 32'h12, 5'd3);
    step(); #1;
    idle_chk("ss_done");

    // Pointer at 3: unit 3 first, then wrap to unit 0; unready offer ignored
    put(0, 32'hC0, 5'd1);
    put(3, 32'hC3, 5'd4);
    step(); clr(); put(0, 32'hBAD, 5'd9); #1;
    bcast_chk("wrap_a", 4'b1000, 32'hC3, 5'd4);
    chk("wrap_ready", 64'(fu_ready), 64'hE);
    step(); clr(); #1;
    bcast_chk("wrap_b", 4'b0001, 32'hC0, 5'd1);
    step(); #1;
    idle_chk("wrap_done");

    // Pointer now 1: unit 1 wins over unit 0
    put(0, 32'hD0, 5'd2);
    put(1, 32'hD1, 5'd2);
    step(); clr(); #1;
    bcast_chk("ptr1_a", 4'b0010, 32'hD1, 5'd2);
    step(); #1;
    bcast_chk("ptr1_b", 4'b0001, 32'hD0, 5'd2);
    step(); #1;

    // Lone grant to unit 3 returns the pointer to 0
    put(3, 32'hE3, 5'd6);
    step(); clr(); #1;
    bcast_chk("to_ptr0", 4'b1000, 32'hE3, 5'd6);
    step(); #1;

    // Full contention from pointer 0
    for (int i = 0; i < N; i++) put(i, XLEN'(32'hA0 + i), TW'(8 + i));
    step(); clr(); #1;
    for (int k = 0; k < N; k++) begin
      exp_rdy = N'((2 << k) - 1);
      bcast_chk("rr", N'(1 << k), XLEN'(32'hA0 + k), TW'(8 + k));
      chk("rr_ready", 64'(fu_ready), 64'(exp_rdy));
      step(); #1;
    end
    idle_chk("rr_done");
    put(0, 32'hF0, 5'd0);
    put(2, 32'hF2, 5'd2);
    step(); clr(); #1;
    bcast_chk("rr_ptr0_a", 4'b0001, 32'hF0, 5'd0);
    step(); #1;
    bcast_chk("rr_ptr0_b", 4'b0100, 32'hF2, 5'd2);
    step(); #1;

    // Flush drops buffered and incoming results, pointer (3) holds
    put(1, 32'h31, 5'd1);
    put(3, 32'h33, 5'd3);
    step(); clr(); put(0, 32'h77, 5'd5); flush = 1'b1; #1;
    idle_chk("fl");
    chk("fl_ready", 64'(fu_ready), 64'd0);
    chk("fl_value", 64'(cdb_value), 64'd0);
    step(); clr(); flush = 1'b0; #1;
    idle_chk("fl_after");
    chk("fl_after_ready", 64'(fu_ready), 64'hF);
    step(); #1;
    idle_chk("fl_unit0_dropped");
    put(0, 32'h90, 5'd0);
    put(3, 32'h93, 5'd3);
    step(); clr(); #1;
    bcast_chk("fl_ptr_a", 4'b1000, 32'h93, 5'd3);
    step(); #1;
    bcast_chk("fl_ptr_b", 4'b0001, 32'h90, 5'd0);
    step(); #1;

    // Asynchronous reset mid-operation discards the pending result, pointer back to 0
    put(2, 32'h42, 5'd2);
    step(); clr(); #1;
    bcast_chk("mr_pre", 4'b0100, 32'h42, 5'd2);
    reset_n = 1'b0;
    #1;
    idle_chk("mr");
    chk("mr_ready", 64'(fu_ready), 64'hF);
    step();
    reset_n = 1'b1;
    #1;
    idle_chk("mr_after");
    put(0, 32'h60, 5'd0);
    put(3, 32'h63, 5'd3);
    step(); clr(); #1;
    bcast_chk("mr_ptr_a", 4'b0001, 32'h60, 5'd0);
    step(); #1;
    bcast_chk("mr_ptr_b", 4'b1000, 32'h63, 5'd3);
    step(); #1;
    idle_chk("mr_done");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
